// File: rtl/max_search_ctrl.sv
// Sequencing controller for the shared max-finder datapath: walks the operand
// mux over N_INPUTS operands, strobes the T register and tracks the max index.
module max_search_ctrl #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  output logic [IDX_W-1:0] sel_x,
  output logic             init_t,
  output logic             ld_t,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] max_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    SCAN   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] count;
  logic [IDX_W-1:0] count_nxt;
  logic [IDX_W-1:0] max_idx_nxt;
  logic [IDX_W-1:0] sel_x_nxt;
  logic             init_t_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // State, counter and registered outputs; outputs are pre-decoded from next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      max_idx <= '0;
      sel_x   <= '0;
      init_t  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      max_idx <= max_idx_nxt;
      sel_x   <= sel_x_nxt;
      init_t  <= init_t_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state, counter and max-index update
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    max_idx_nxt = max_idx;
    sel_x_nxt   = '0;
    init_t_nxt  = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_nxt = INIT;
      end
      INIT: begin
        max_idx_nxt = '0;
        count_nxt   = ONE;
        state_nxt   = SCAN;
      end
      SCAN: begin
        // Strict compare: an equal later operand never displaces the current max
        if (cmp_gt) max_idx_nxt = count;
        if (count == LAST_IDX) state_nxt = FINISH;
        else                   count_nxt = count + ONE;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    init_t_nxt = (state_nxt == INIT);
    busy_nxt   = (state_nxt == INIT) || (state_nxt == SCAN);
    done_nxt   = (state_nxt == FINISH);
    sel_x_nxt  = (state_nxt == SCAN) ? count_nxt : '0;
  end

  // Conditional T load follows the comparator in the same cycle
  assign ld_t = (state == SCAN) && cmp_gt;

endmodule
